// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Upstream feeder of the tile configuration chain. Bitstream words arrive on
// a valid/ready handshake. Each word is shifted MSB-first onto the head of the
// configurable-memory DFF chain, one bit per prog_clk cycle. For every bit
// shifted, a per-bit enable is raised so the chain's prog_clk gate lets the
// bit move. The loader counts shifted bits up to CHAIN_LEN and ends the
// session when the count is reached. While shifting, it watches ccff_tail:
// the chain is all-zero after reset, so any 1 seen on the tail during a
// session is reported as a chain integrity error.
//
// Ports
//   prog_clk       in   programming clock, rising edge
//   pReset         in   asynchronous active-high reset
//   start          in   one-cycle pulse, begins a session (IDLE/DONE only)
//   cfg_data       in   bitstream word, MSB shifted first
//   cfg_valid      in   cfg_data valid
//   cfg_ready      out  word accepted this cycle when cfg_valid is high
//   ccff_head      out  serial bit into the chain head
//   ccff_shift_en  out  chain shifts on this edge (clock-gate enable)
//   ccff_tail      in   serial bit leaving the chain tail
//   busy           out  session in progress
//   done           out  CHAIN_LEN bits shifted (sticky)
//   tail_err       out  a 1 was seen on ccff_tail while shifting (sticky)
//   bit_count      out  bits shifted in the current or last session
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
  parameter int WORD_WIDTH = 8,
  parameter int CHAIN_LEN  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  tail_err,
  output logic [CNT_WIDTH-1:0]  bit_count
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WORD_WIDTH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CHAIN_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] sreg_q,  sreg_d;   // word being serialized, MSB is next bit
  logic [IDX_W-1:0]      idx_q,   idx_d;    // bits left in word minus one
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic                  done_q,  done_d;
  logic                  err_q,   err_d;
  logic                  head_q,  head_d;   // last bit driven, held while stalled

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    err_d         = err_q;
    head_d        = head_q;
    cfg_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          head_d  = 1'b0;
        end
      end

      S_FETCH: begin
        busy      = 1'b1;
        cfg_ready = 1'b1;
        ccff_head = head_q;
        if (cfg_valid) begin
          sreg_d  = cfg_data;
          idx_d   = LAST_IDX;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = sreg_q[WORD_WIDTH-1];
        head_d        = sreg_q[WORD_WIDTH-1];
        sreg_d        = sreg_q << 1;
        idx_d         = idx_q - IDX_ONE;
        cnt_d         = cnt_q + CNT_ONE;
        // The chain starts all-zero, so a 1 on the tail means a broken chain.
        if (ccff_tail) begin
          err_d = 1'b1;
        end
        if (cnt_q == LAST_CNT) begin
          // Final chain bit: the session ends here and any unshifted low bits
          // of this word are dropped, so no new word may be accepted.
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (idx_q == '0) begin
          // Last bit of the word: accept the next one now to avoid a bubble.
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            sreg_d = cfg_data;
            idx_d  = LAST_IDX;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      head_q  <= head_d;
    end
  end

  assign done      = done_q;
  assign tail_err  = err_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
//
// Two loader instances share one clock and reset: one has a 16-bit chain, and
// one has a 12-bit chain for the truncation case. The variable sel routes the
// stimulus to one instance at a time and selects which outputs are observed.
// A bit-queue model predicts every output on every cycle. It tracks the bits
// still owed to the chain, the bits shifted so far, and the sticky flags.
// Directed scenarios add literal expectations on the captured head stream.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;

  localparam int WW = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;
  logic          tail;
  logic          sel;       // 0: 16-bit chain instance, 1: 12-bit chain instance

  logic          a_ready, a_head, a_shen, a_busy, a_done, a_err;
  logic [CW-1:0] a_cnt;
  logic          b_ready, b_head, b_shen, b_busy, b_done, b_err;
  logic [CW-1:0] b_cnt;

  logic          a_start, a_valid, a_tail, b_start, b_valid, b_tail;
  assign a_start = start & ~sel;
  assign a_valid = cfg_valid & ~sel;
  assign a_tail  = tail & ~sel;
  assign b_start = start & sel;
  assign b_valid = cfg_valid & sel;
  assign b_tail  = tail & sel;

  ccff_bitstream_loader #(.WORD_WIDTH(WW), .CHAIN_LEN(16), .CNT_WIDTH(CW)) dut_a (
    .prog_clk(clk), .pReset(rst), .start(a_start), .cfg_data(cfg_data),
    .cfg_valid(a_valid), .cfg_ready(a_ready), .ccff_head(a_head),
    .ccff_shift_en(a_shen), .ccff_tail(a_tail), .busy(a_busy), .done(a_done),
    .tail_err(a_err), .bit_count(a_cnt)
  );

  ccff_bitstream_loader #(.WORD_WIDTH(WW), .CHAIN_LEN(12), .CNT_WIDTH(CW)) dut_b (
    .prog_clk(clk), .pReset(rst), .start(b_start), .cfg_data(cfg_data),
    .cfg_valid(b_valid), .cfg_ready(b_ready), .ccff_head(b_head),
    .ccff_shift_en(b_shen), .ccff_tail(b_tail), .busy(b_busy), .done(b_done),
    .tail_err(b_err), .bit_count(b_cnt)
  );

  logic          ready, head, shen, busy, done, err;
  logic [CW-1:0] cnt;
  assign ready = sel ? b_ready : a_ready;
  assign head  = sel ? b_head  : a_head;
  assign shen  = sel ? b_shen  : a_shen;
  assign busy  = sel ? b_busy  : a_busy;
  assign done  = sel ? b_done  : a_done;
  assign err   = sel ? b_err   : a_err;
  assign cnt   = sel ? b_cnt   : a_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit q[$];          // bits accepted but not yet shifted into the chain
  int m_cnt    = 0;
  bit m_active = 0;
  bit m_done   = 0;
  bit m_err    = 0;
  bit m_last   = 0;  // last bit sent to the chain

  function automatic int m_len();
    return sel ? 12 : 16;
  endfunction

  function automatic bit e_shen();
    return m_active && (q.size() > 0);
  endfunction

  function automatic bit e_ready();
    if (!m_active) return 1'b0;
    if (q.size() == 0) return 1'b1;
    return (q.size() == 1) && (m_cnt + 1 != m_len());
  endfunction

  function automatic bit e_head();
    if (!m_active) return 1'b0;
    return (q.size() > 0) ? q[0] : m_last;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_cnt = 0; m_active = 0; m_done = 0; m_err = 0; m_last = 0;
      end else begin
        bit sh, rd, was_active;
        sh = e_shen();
        rd = e_ready();
        was_active = m_active;
        if (sh) begin
          m_last = q.pop_front();
          m_cnt++;
          if (tail) m_err = 1;
          if (m_cnt == m_len()) begin
            m_active = 0;
            m_done   = 1;
            q.delete();
          end
        end
        if (rd && cfg_valid) begin
          for (int b = WW - 1; b >= 0; b--) q.push_back(cfg_data[b]);
        end
        if (!was_active && start) begin
          m_active = 1; m_cnt = 0; m_done = 0; m_err = 0; m_last = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare and head capture ----------------
  logic [31:0] cap;
  int n_shift, first_cyc, last_cyc, cyc;
  logic last_ready;

  initial begin
    cap = 0; n_shift = 0; first_cyc = 0; last_cyc = 0; cyc = 0; last_ready = 0;
    forever begin
      @(negedge clk);
      check("busy",      busy,  m_active);
      check("cfg_ready", ready, e_ready());
      check("shift_en",  shen,  e_shen());
      check("ccff_head", head,  e_head());
      check("done",      done,  m_done);
      check("tail_err",  err,   m_err);
      check("bit_count", cnt,   m_cnt);
      if (shen === 1'b1) begin
        cap = {cap[30:0], head};
        if (n_shift == 0) first_cyc = cyc;
        last_cyc   = cyc;
        last_ready = ready;
        n_shift++;
      end
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic s);
    rst = 1'b1; sel = s; start = 1'b0; cfg_valid = 1'b0; tail = 1'b0; cfg_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic new_session();
    cap = 0; n_shift = 0;
    do_start();
  endtask

  task automatic offer(input logic [WW-1:0] w);
    bit acc;
    acc = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = ready;
      tick();
    end
    cfg_valid = 1'b0;
    check("word_accepted", acc, 1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check("done_reached", done, 1'b1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1; sel = 1'b0; start = 1'b0; cfg_valid = 1'b0; tail = 1'b0; cfg_data = '0;

    // Back-to-back words, 16-bit chain.
    do_reset(1'b0);
    @(negedge clk);
    check("reset_busy",  busy,  1'b0);
    check("reset_count", cnt,   16'd0);
    tick();
    new_session();
    @(negedge clk);
    check("ready_after_start", ready, 1'b1);
    tick();
    offer(8'hA5);
    offer(8'h3C);
    wait_done();
    check("s1_stream", cap[15:0], 16'hA53C);
    check("s1_shifts", n_shift, 16);
    check("s1_no_gap", last_cyc - first_cyc, 15);
    check("s1_busy",   busy, 1'b0);
    check("s1_count",  cnt,  16'd16);
    tick();

    // Truncated final word, 12-bit chain.
    do_reset(1'b1);
    new_session();
    offer(8'hFF);
    offer(8'h0F);
    wait_done();
    check("s2_stream",     cap[11:0], 12'hFF0);
    check("s2_shifts",     n_shift, 12);
    check("s2_last_ready", last_ready, 1'b0);
    check("s2_count",      cnt, 16'd12);
    tick();

    // Three-cycle gap between words.
    do_reset(1'b0);
    new_session();
    offer(8'hA5);
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gap_shift_en", shen, 1'b0);
      check("gap_count",    cnt,  16'd8);
      check("gap_head",     head, 1'b1);
      tick();
    end
    offer(8'h3C);
    wait_done();
    check("s3_stream", cap[15:0], 16'hA53C);
    check("s3_span",   last_cyc - first_cyc, 19);
    tick();

    // Tail integrity error on the 5th shift, then cleared by a new start.
    do_reset(1'b0);
    new_session();
    offer(8'h81);
    repeat (4) tick();
    tail = 1'b1;
    tick();
    tail = 1'b0;
    @(negedge clk);
    check("s4_err_set", err, 1'b1);
    tick();
    offer(8'h42);
    wait_done();
    check("s4_err_at_done", err, 1'b1);
    tick();
    new_session();
    @(negedge clk);
    check("s4_err_cleared", err,   1'b0);
    check("s4_done_clr",    done,  1'b0);
    check("s4_cnt_clr",     cnt,   16'd0);
    check("s4_ready",       ready, 1'b1);
    tick();
    offer(8'h00);
    offer(8'hFF);
    wait_done();
    check("s4b_stream", cap[15:0], 16'h00FF);
    tick();

    // Asynchronous reset after 7 shifts.
    do_reset(1'b0);
    new_session();
    offer(8'hA5);
    repeat (7) tick();
    check("s5_pre_count", cnt,  16'd7);
    check("s5_pre_head",  head, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("s5_async_busy",  busy,  1'b0);
    check("s5_async_shen",  shen,  1'b0);
    check("s5_async_head",  head,  1'b0);
    check("s5_async_count", cnt,   16'd0);
    check("s5_async_ready", ready, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("s5_idle_busy", busy, 1'b0);
    tick();
    new_session();
    offer(8'h5A);
    offer(8'hC3);
    wait_done();
    check("s5_stream", cap[15:0], 16'h5AC3);
    check("s5_count",  cnt, 16'd16);
    tick();

    // start during SHIFT is ignored; start in DONE restarts.
    do_reset(1'b0);
    new_session();
    offer(8'h96);
    do_start();
    offer(8'h69);
    wait_done();
    check("s6_stream", cap[15:0], 16'h9669);
    check("s6_shifts", n_shift, 16);
    tick();
    do_start();
    @(negedge clk);
    check("s6_done_clr", done,  1'b0);
    check("s6_cnt_clr",  cnt,   16'd0);
    check("s6_ready",    ready, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
